vec_reg_file_masked: RTL and testbench

Parametrised vector register file for the vector datapath decode stage: REGS registers of LANES lanes × N bits, two combinational read ports and one synchronous write port. Adds per-lane write masking, scalar-broadcast writes, write-to-read bypass, an asynchronous zeroing reset, and a handshaked multi-cycle clear sweep.

---
 rtl/vec_reg_file_masked.sv | 127 ++++++++++++
 tb/tb_vec_reg_file_masked.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_reg_file_masked.sv
// Vector register file: two combinational read ports, one masked/broadcast write
// port with write-to-read bypass, and a handshaked sweep that zeroes one register per cycle.
module vec_reg_file_masked #(
  parameter  int N     = 20,
  parameter  int LANES = 8,
  parameter  int REGS  = 16,
  localparam int AW    = $clog2(REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we3,
  input  logic [AW-1:0]        ra1,
  input  logic [AW-1:0]        ra2,
  input  logic [AW-1:0]        ra3,
  input  logic [LANES*N-1:0]   wd3,
  input  logic [LANES-1:0]     wmask,
  input  logic                 bcast,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic [LANES*N-1:0]   rd1,
  output logic [LANES*N-1:0]   rd2
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [LANES*N-1:0]   mem_q [REGS];
  logic [LANES*N-1:0]   mem_d [REGS];
  logic [LANES*N-1:0]   eff;
  logic                 wr_in_range;
  logic                 wr_acc;
  logic [1:0][AW-1:0]   ra_p;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_eff
      assign eff[gi*N +: N] = bcast ? wd3[N-1:0] : wd3[gi*N +: N];
    end
  endgenerate

  // Gating with reset keeps the bypass path from leaking write data while reset is held.
  assign wr_in_range = ({1'b0, ra3} < (AW+1)'(REGS));
  assign wr_acc      = we3 && reset && (state_q != SWEEP) && wr_in_range;

  assign clr_busy = (state_q == SWEEP);
  assign clr_done = (state_q == DONE);

  assign ra_p = {ra2, ra1};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic               in_range;
      logic [LANES*N-1:0] rd_v;
      assign in_range = ({1'b0, ra_p[gi]} < (AW+1)'(REGS));
      always_comb begin
        rd_v = '0;
        if (in_range) begin
          rd_v = mem_q[ra_p[gi]];
          if (wr_acc && (ra3 == ra_p[gi])) begin
            for (int l = 0; l < LANES; l++) begin
              if (wmask[l]) rd_v[l*N +: N] = eff[l*N +: N];
            end
          end
        end
      end
    end
  endgenerate

  assign rd1 = g_rd[0].rd_v;
  assign rd2 = g_rd[1].rd_v;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(REGS-1)) begin
          state_d = DONE;
          ptr_d   = '0;
        end
      end
      DONE: begin
        ptr_d = '0;
        if (clr_req) state_d = SWEEP;
        else         state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // The sweep owns the array while busy; writes are only merged outside SWEEP.
  always_comb begin
    for (int r = 0; r < REGS; r++) mem_d[r] = mem_q[r];
    if (state_q == SWEEP) begin
      mem_d[ptr_q] = '0;
    end else if (wr_acc) begin
      for (int l = 0; l < LANES; l++) begin
        if (wmask[l]) mem_d[ra3][l*N +: N] = eff[l*N +: N];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int r = 0; r < REGS; r++) mem_q[r] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int r = 0; r < REGS; r++) mem_q[r] <= mem_d[r];
    end
  end

endmodule

// File: tb/tb_vec_reg_file_masked.sv
// Directed bench for vec_reg_file_masked: reset, masked/broadcast writes with bypass,
// clear sweep timing, asynchronous reset mid-sweep and back-to-back sweeps.
module tb_vec_reg_file_masked;
  localparam int N = 20, LANES = 8, REGS = 16, AW = 4, W = N*LANES;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           we3 = 1'b0, bcast = 1'b0, clr_req = 1'b0;
  logic [AW-1:0]  ra1 = '0, ra2 = '0, ra3 = '0;
  logic [W-1:0]   wd3 = '0;
  logic [LANES-1:0] wmask = '0;
  logic           clr_busy, clr_done;
  logic [W-1:0]   rd1, rd2;
  int             checks = 0, failures = 0;

  always #5 clk = ~clk;

  vec_reg_file_masked #(.N(N), .LANES(LANES), .REGS(REGS)) dut (
    .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .wd3(wd3), .wmask(wmask), .bcast(bcast), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done), .rd1(rd1), .rd2(rd2)
  );

  function automatic logic [W-1:0] vec(input int base);
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*N +: N] = N'(base + i);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    we3 = 1'b1; ra3 = 0; wd3 = vec(100); wmask = '1;
    for (int a = 0; a < REGS; a++) begin
      ra1 = AW'(a); ra2 = AW'(REGS-1-a);
      #1;
      checks++;
      if (rd1 !== '0) begin failures++; $display("FAIL reset_rd1[%0d]: got %h expected 0", a, rd1); end
      checks++;
      if (rd2 !== '0) begin failures++; $display("FAIL reset_rd2[%0d]: got %h expected 0", a, rd2); end
    end
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
    end
    tick;
    we3 = 1'b0; ra1 = 0;
    reset = 1'b1;
    #1;
    checks++;
    if (rd1 !== '0) begin failures++; $display("FAIL reset_write_ignored: got %h expected 0", rd1); end
    $display("test_reset complete");
  endtask

  task automatic test_write_bypass;
    tick;
    we3 = 1'b1; ra3 = 5; wmask = '1; bcast = 1'b0; wd3 = vec(1); ra1 = 5; ra2 = 4;
    #1;
    checks++;
    if (rd1 !== vec(1)) begin failures++; $display("FAIL bypass_rd1: got %h expected %h", rd1, vec(1)); end
    checks++;
    if (rd2 !== '0) begin failures++; $display("FAIL nobypass_rd2: got %h expected 0", rd2); end
    tick;
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== vec(1)) begin failures++; $display("FAIL stored_rd1: got %h expected %h", rd1, vec(1)); end
    $display("test_write_bypass complete");
  endtask

  task automatic test_mask_bcast;
    logic [W-1:0] exp_v;
    exp_v = vec(1);
    exp_v[0*N +: N] = 20'hABCDE;
    exp_v[2*N +: N] = 20'hABCDE;
    tick;
    we3 = 1'b1; ra3 = 5; wmask = 8'b0000_0101; bcast = 1'b1;
    wd3 = '1; wd3[N-1:0] = 20'hABCDE;
    ra1 = 5; ra2 = 5;
    #1;
    checks++;
    if (rd1 !== exp_v) begin failures++; $display("FAIL mask_bypass_rd1: got %h expected %h", rd1, exp_v); end
    checks++;
    if (rd2 !== exp_v) begin failures++; $display("FAIL mask_bypass_rd2: got %h expected %h", rd2, exp_v); end
    tick;
    wmask = '0; bcast = 1'b0; wd3 = '0;
    #1;
    checks++;
    if (rd1 !== exp_v) begin failures++; $display("FAIL nomask_bypass: got %h expected %h", rd1, exp_v); end
    tick;
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== exp_v) begin failures++; $display("FAIL mask_stored: got %h expected %h", rd1, exp_v); end
    $display("test_mask_bcast complete");
  endtask

  task automatic test_sweep;
    for (int k = 0; k < REGS; k++) begin
      tick;
      we3 = 1'b1; ra3 = AW'(k); wmask = '1; bcast = 1'b0; wd3 = vec(k*16 + 1);
    end
    tick;
    we3 = 1'b0; clr_req = 1'b1; ra1 = 0;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin failures++; $display("FAIL sweep_pre_busy: got %b expected 0", clr_busy); end
    tick;
    clr_req = 1'b0;
    for (int c = 0; c < REGS; c++) begin
      we3 = (c == 8);
      ra3 = 15; wmask = '1; wd3 = vec(999);
      ra1 = AW'(c);
      ra2 = (c == 8) ? AW'(15) : AW'((c == 0) ? 0 : c - 1);
      #1;
      checks++;
      if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin
        failures++; $display("FAIL sweep_flags[%0d]: got busy=%b done=%b expected 1 0", c, clr_busy, clr_done);
      end
      checks++;
      if (rd1 !== vec(c*16 + 1)) begin
        failures++; $display("FAIL sweep_pending[%0d]: got %h expected %h", c, rd1, vec(c*16 + 1));
      end
      if (c == 8) begin
        checks++;
        if (rd2 !== vec(15*16 + 1)) begin
          failures++; $display("FAIL sweep_no_bypass: got %h expected %h", rd2, vec(15*16 + 1));
        end
      end else if (c > 0) begin
        checks++;
        if (rd2 !== '0) begin failures++; $display("FAIL sweep_cleared[%0d]: got %h expected 0", c - 1, rd2); end
      end
      tick;
    end
    we3 = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b1) begin
      failures++; $display("FAIL sweep_done: got busy=%b done=%b expected 0 1", clr_busy, clr_done);
    end
    tick;
    ra1 = 15; ra2 = 8;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++; $display("FAIL sweep_idle: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
    end
    checks++;
    if (rd1 !== '0) begin failures++; $display("FAIL sweep_reg15: got %h expected 0", rd1); end
    checks++;
    if (rd2 !== '0) begin failures++; $display("FAIL sweep_reg8: got %h expected 0", rd2); end
    $display("test_sweep complete");
  endtask

  task automatic test_reset_mid_sweep;
    int cnt;
    bit seen;
    tick;
    we3 = 1'b1; ra3 = 10; wmask = '1; wd3 = vec(50);
    tick;
    ra3 = 12; wd3 = vec(70);
    tick;
    we3 = 1'b0; clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    repeat (7) tick;
    ra1 = 10; ra2 = 12;
    #1;
    checks++;
    if (rd1 !== vec(50)) begin failures++; $display("FAIL midsweep_pre: got %h expected %h", rd1, vec(50)); end
    reset = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++; $display("FAIL async_reset_flags: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
    end
    checks++;
    if (rd1 !== '0 || rd2 !== '0) begin
      failures++; $display("FAIL async_reset_regs: got %h %h expected 0 0", rd1, rd2);
    end
    tick;
    clr_req = 1'b1; we3 = 1'b1; ra3 = 10; wd3 = vec(3);
    #1;
    checks++;
    if (clr_busy !== 1'b0 || rd1 !== '0) begin
      failures++; $display("FAIL reset_held_ignore: got busy=%b rd1=%h expected 0 0", clr_busy, rd1);
    end
    we3 = 1'b0;
    reset = 1'b1;
    tick;
    clr_req = 1'b0;
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (clr_busy) cnt++;
      if (clr_done) seen = 1'b1;
      else tick;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL fresh_sweep_timeout: got no done expected done within 40 cycles"); end
    checks++;
    if (cnt != REGS) begin failures++; $display("FAIL fresh_sweep_len: got %0d expected %0d", cnt, REGS); end
    $display("test_reset_mid_sweep complete");
  endtask

  task automatic test_back_to_back;
    bit seen;
    bit exp_done;
    logic [W-1:0] exp_rd;
    tick;
    clr_req = 1'b1; ra1 = 3;
    tick;
    for (int n = 0; n <= 34; n++) begin
      we3 = (n == 16); ra3 = 3; wmask = '1; bcast = 1'b0; wd3 = vec(32'h500);
      exp_done = (n == 16) || (n == 33);
      exp_rd = (n >= 16 && n <= 20) ? vec(32'h500) : '0;
      #1;
      checks++;
      if (clr_done !== exp_done || clr_busy !== !exp_done) begin
        failures++;
        $display("FAIL b2b_flags[%0d]: got busy=%b done=%b expected %b %b", n, clr_busy, clr_done, !exp_done, exp_done);
      end
      checks++;
      if (rd1 !== exp_rd) begin failures++; $display("FAIL b2b_reg3[%0d]: got %h expected %h", n, rd1, exp_rd); end
      tick;
    end
    we3 = 1'b0; clr_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (clr_done) seen = 1'b1;
      else tick;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL b2b_final_timeout: got no done expected done within 40 cycles"); end
    tick;
    $display("test_back_to_back complete");
  endtask

  initial begin
    test_reset;
    test_write_bypass;
    test_mask_bcast;
    test_sweep;
    test_reset_mid_sweep;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
